// File: rtl/call_return_ctrl.sv
// call_return_ctrl
//   Initiator side of a hardware return-address stack. Converts call/return
//   requests from decode into push / top-of-stack-read / pop strobe sequences,
//   keeps a count of stack occupancy, raises sticky overflow/underflow flags,
//   and hands the popped return address to fetch over a valid/ready redirect.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   call_req, ret_req decode requests, sampled only while idle
//   call_pc           PC of the call instruction
//   redirect_ready    fetch accepts redirect_pc
//   stack_data        top-of-stack value from the stack
//   err_clear         clears the sticky error flags
//   push_sig, pop_sig, tos_sig, push_data   stack control
//   redirect_valid, redirect_pc             redirect to fetch
//   busy              controller not idle, decode must stall
//   depth             current occupancy (0..DEPTH)
//   overflow          sticky: call issued while full
//   underflow         sticky: return issued while empty
module call_return_ctrl #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             call_req,
  input  logic             ret_req,
  input  logic [WIDTH-1:0] call_pc,
  input  logic             redirect_ready,
  input  logic [WIDTH-1:0] stack_data,
  input  logic             err_clear,
  output logic             push_sig,
  output logic             pop_sig,
  output logic             tos_sig,
  output logic [WIDTH-1:0] push_data,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             busy,
  output logic [CNT_W-1:0] depth,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PUSH  = 3'd1;
  localparam logic [2:0] S_TOS   = 3'd2;
  localparam logic [2:0] S_POP   = 3'd3;
  localparam logic [2:0] S_REDIR = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [WIDTH-1:0] push_data_q;
  logic [WIDTH-1:0] ret_q;
  logic [CNT_W-1:0] depth_q;
  logic             ovf_q, unf_q;

  logic full, empty, idle;
  logic do_call, do_ret, ovf_evt, unf_evt;

  assign idle  = (state == S_IDLE);
  assign full  = (depth_q == CNT_W'(DEPTH));
  assign empty = (depth_q == '0);

  // A call always takes priority; a return arriving with it is dropped.
  assign do_call = idle && call_req && !full;
  assign do_ret  = idle && !call_req && ret_req && !empty;
  assign ovf_evt = idle && call_req && full;
  assign unf_evt = idle && !call_req && ret_req && empty;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (do_call)     state_nxt = S_PUSH;
        else if (do_ret) state_nxt = S_TOS;
      end
      S_PUSH:  state_nxt = S_IDLE;
      S_TOS:   state_nxt = S_POP;
      S_POP:   state_nxt = S_REDIR;
      S_REDIR: if (redirect_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      push_data_q <= '0;
      ret_q       <= '0;
      depth_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      // Return address is the instruction after the call; wraps mod 2^WIDTH.
      if (do_call) push_data_q <= call_pc + WIDTH'(1);
      if (state == S_PUSH) depth_q <= depth_q + CNT_W'(1);
      // Stack drives the top entry during TOS and holds it through POP;
      // capture it at the POP exit edge together with the decrement.
      if (state == S_POP) begin
        ret_q   <= stack_data;
        depth_q <= depth_q - CNT_W'(1);
      end
      // A new error in the same cycle as err_clear leaves the flag set.
      ovf_q <= ovf_evt | (ovf_q & ~err_clear);
      unf_q <= unf_evt | (unf_q & ~err_clear);
    end
  end

  // Strobes decode straight from state, so each lasts exactly one cycle,
  // they are mutually exclusive, and they drop as soon as reset asserts.
  assign push_sig       = (state == S_PUSH);
  assign tos_sig        = (state == S_TOS);
  assign pop_sig        = (state == S_POP);
  assign redirect_valid = (state == S_REDIR);
  assign push_data      = push_data_q;
  assign redirect_pc    = ret_q;
  assign busy           = !idle;
  assign depth          = depth_q;
  assign overflow       = ovf_q;
  assign underflow      = unf_q;

endmodule

// File: doc/call_return_ctrl.md
Name: call_return_ctrl

Overview:
- Initiator side of the 12-bit hardware return-address stack (push_sig/pop_sig/tos_sig/push_data/out_data interface).
- Turns call/return requests from decode into correctly sequenced stack operations.
- Tracks stack occupancy and flags overflow and underflow.
- Delivers the popped return address to fetch through a valid/ready redirect handshake.

Parameters:
- WIDTH, 12, PC/stack data width.
- DEPTH, 8, stack entries; must match the stack instance.
- CNT_W, 4, occupancy counter width; must hold values 0..DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- call_req  in  1  decode: call instruction present; sampled only in IDLE.
- ret_req  in  1  decode: return instruction present; sampled only in IDLE.
- call_pc  in  WIDTH  PC of the call instruction.
- redirect_ready  in  1  fetch accepts redirect_pc.
- stack_data  in  WIDTH  stack out_data (top of stack).
- err_clear  in  1  clears sticky error flags.
- push_sig  out  1  to stack: push strobe.
- pop_sig  out  1  to stack: pop strobe.
- tos_sig  out  1  to stack: top-of-stack read strobe.
- push_data  out  WIDTH  to stack: return address.
- redirect_valid  out  1  redirect_pc valid.
- redirect_pc  out  WIDTH  return target.
- busy  out  1  controller not in IDLE; decode must stall.
- depth  out  CNT_W  current occupancy.
- overflow  out  1  sticky: call issued while full.
- underflow  out  1  sticky: return issued while empty.

Behaviour:
- Reset (async, any state):
  - State returns to IDLE; depth=0.
  - All outputs are 0; push_data, redirect_pc and the internal return register are 0.
  - Reset mid-operation aborts that operation; the aborted operation produces no strobe after reset deasserts.
- States: IDLE, PUSH, TOS, POP, REDIR. busy = (state != IDLE).
- IDLE, request handling:
  - call_req=1 and ret_req=1 together: the call is serviced and the return is dropped silently.
  - call_req=1, depth<DEPTH: latch push_data = (call_pc+1) mod 2^WIDTH (wrap 0xFFF -> 0x000), then go to PUSH.
  - call_req=1, depth==DEPTH: set overflow, issue no push, stay in IDLE.
  - ret_req=1 (no call), depth>0: go to TOS.
  - ret_req=1 (no call), depth==0: set underflow, issue no strobes, assert no redirect, stay in IDLE.
- PUSH (1 cycle): push_sig=1; depth increments at the exiting edge; then IDLE.
- TOS (1 cycle): tos_sig=1; the stack presents the top entry on stack_data during this cycle; then POP.
- POP (1 cycle):
  - pop_sig=1; tos_sig=0.
  - Capture stack_data into the return register at the exiting edge.
  - depth decrements at the same edge; then REDIR.
- REDIR:
  - redirect_valid=1 and redirect_pc=return register; both held stable until redirect_ready=1.
  - The cycle with redirect_ready=1 completes the transfer; next state IDLE, redirect_valid drops.
- Strobes: every strobe is exactly one cycle long, and push_sig, pop_sig and tos_sig are never high together.
- Latency (request sampled at edge N):
  - Call: push_sig high in cycle N..N+1; next request sampled at edge N+2.
  - Return: tos_sig in cycle N..N+1, pop_sig in N+1..N+2, redirect_valid from N+2.
  - With redirect_ready tied high, the next request is sampled at edge N+4.
- Requests arriving while busy=1 are ignored; decode holds them until busy=0.
- depth range: 0..DEPTH; it never wraps.
- Sticky flags: overflow and underflow stay set until err_clear=1 or reset. err_clear and a new error in the same cycle: the flag is set (set wins).

Test Plan:
- Reset, then call_req with call_pc=0x010 -> push_data=0x011, push_sig high one cycle at edge+1, depth=1, busy back to 0 after 2 cycles.
- Call 0x100, call 0x200, then ret with redirect_ready=1 -> tos_sig, then pop_sig, then redirect_pc=0x201; a second ret gives 0x101; depth goes 2 -> 1 -> 0.
- Nine calls with DEPTH=8 -> 8 push strobes, depth=8, overflow=1 and no ninth push_sig; err_clear -> overflow=0.
- ret on empty stack -> underflow=1, no tos_sig/pop_sig/redirect_valid; call_pc=0xFFF -> push_data=0x000.
- redirect_ready held low 5 cycles in REDIR -> redirect_valid and redirect_pc stable; a new call_req during the stall is ignored; accepted on the cycle ready goes high.
- rst asserted during TOS -> all outputs 0 immediately, depth=0, no pop_sig after release; simultaneous call_req+ret_req in IDLE -> only the push occurs.
